div_seq_8bit: RTL and testbench



---
 rtl/div_seq_8bit_if.sv | 35 +++
 rtl/div_seq_8bit.sv | 129 ++++++++++++
 tb/tb_div_seq_8bit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_8bit_if.sv
// Start/operand/result bundle of the sequential divider: master drives requests, slave returns results.
interface div_seq_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/div_seq_8bit.sv
// Sequential restoring divider (one quotient bit per clock) feeding mux input I0 of the ALU DIV path.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips RUN and completes on the accepting edge.
module div_seq_8bit #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    div_seq_8bit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   partRem_q, partRem_d;
    logic [WIDTH-1:0] quoWork_q, quoWork_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             divByZero_q, divByZero_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic [WIDTH:0]   remNext;
    logic [WIDTH-1:0] quoNext;
    logic             unusedRemMsb;

    // The stored partial remainder is always below the divisor, so its top bit is shifted out unread.
    assign shifted      = {partRem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
    assign trial        = {1'b0, shifted} - {2'b00, divisor_q};
    assign fits         = ~trial[WIDTH+1];
    assign remNext      = fits ? trial[WIDTH:0] : shifted;
    assign quoNext      = {quoWork_q[WIDTH-2:0], fits};
    assign unusedRemMsb = partRem_q[WIDTH];

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        partRem_d   = partRem_q;
        quoWork_d   = quoWork_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    dividend_d = bus.dividend;
                    divisor_d  = bus.divisor;
                    partRem_d  = '0;
                    quoWork_d  = '0;
                    count_d    = CW'(WIDTH - 1);
                    state_d    = RUN;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        divByZero_d = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end
            end

            RUN: begin
                partRem_d  = remNext;
                quoWork_d  = quoNext;
                dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
                count_d    = count_q - 1'b1;
                if (count_q == '0) begin
                    quotient_d  = quoNext;
                    remainder_d = remNext[WIDTH-1:0];
                    divByZero_d = (divisor_q == '0);
                    state_d     = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            partRem_q   <= '0;
            quoWork_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            partRem_q   <= partRem_d;
            quoWork_q   <= quoWork_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = divByZero_q;

endmodule

// File: tb/tb_div_seq_8bit.sv
// Self-checking bench for div_seq_8bit: directed scenarios plus random operands against an arithmetic model.
module tb_div_seq_8bit;

    localparam int WIDTH   = 8;
    localparam int MAXWAIT = 40;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [WIDTH-1:0] lastQ = '0;
    logic [WIDTH-1:0] lastR = '0;

    div_seq_8bit_if #(.WIDTH(WIDTH)) bus ();

    div_seq_8bit #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned division; a zero divisor yields all ones and the dividend back.
    function automatic void refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                   output logic z, output int lat);
        if (b == 0) begin
            q   = '1;
            r   = a;
            z   = 1'b1;
            lat = FAST ? 0 : WIDTH;
        end else begin
            q   = a / b;
            r   = a % b;
            z   = 1'b0;
            lat = WIDTH;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busyCnt);
        cycles  = 0;
        busyCnt = 0;
        while (bus.done !== 1'b1 && cycles < MAXWAIT) begin
            if (bus.busy === 1'b1) busyCnt++;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", bus.done); end
        checks++; if (bus.quotient !== '0) begin errors++; $display("[TB] FAIL reset_quotient got %0d want 0", bus.quotient); end
        checks++; if (bus.remainder !== '0) begin errors++; $display("[TB] FAIL reset_remainder got %0d want 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got %0b want 0", bus.div_by_zero); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset got busy=%0b done=%0b want 0/0", bus.busy, bus.done); end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] q, r;
        logic             z;
        int               lat, cycles, busyCnt;
        refDiv(8'd200, 8'd7, q, r, z, lat);
        issue(8'd200, 8'd7);
        bus.dividend = 8'd3;
        bus.divisor  = 8'd1;
        waitDone(cycles, busyCnt);
        checks++; if (cycles != lat) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", cycles, lat); end
        checks++; if (busyCnt != WIDTH) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want %0d", busyCnt, WIDTH); end
        checks++; if (bus.quotient !== q) begin errors++; $display("[TB] FAIL basic_quotient got %0d want %0d", bus.quotient, q); end
        checks++; if (bus.remainder !== r) begin errors++; $display("[TB] FAIL basic_remainder got %0d want %0d", bus.remainder, r); end
        checks++; if (bus.div_by_zero !== z) begin errors++; $display("[TB] FAIL basic_dbz got %0b want %0b", bus.div_by_zero, z); end
        lastQ = q;
        lastR = r;
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %0b want 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int cycles, busyCnt;
        issue(8'd255, 8'd1);
        waitDone(cycles, busyCnt);
        checks++; if (bus.quotient !== 8'd255 || bus.remainder !== 8'd0) begin errors++; $display("[TB] FAIL b2b_first got q=%0d r=%0d want 255/0", bus.quotient, bus.remainder); end
        issue(8'd5, 8'd9);
        bus.dividend = 8'd250;
        bus.divisor  = 8'd2;
        checks++; if (bus.busy !== 1'b1 || bus.quotient !== 8'd255) begin errors++; $display("[TB] FAIL b2b_accept got busy=%0b q=%0d want 1/255", bus.busy, bus.quotient); end
        waitDone(cycles, busyCnt);
        checks++; if (cycles + 1 != WIDTH + 1) begin errors++; $display("[TB] FAIL b2b_spacing got %0d want %0d", cycles + 1, WIDTH + 1); end
        checks++; if (bus.quotient !== 8'd0 || bus.remainder !== 8'd5) begin errors++; $display("[TB] FAIL b2b_second got q=%0d r=%0d want 0/5", bus.quotient, bus.remainder); end
        lastQ = 8'd0;
        lastR = 8'd5;
        tick();
    endtask

    task automatic test_ignore_start();
        int cycles;
        int unstable;
        int spurious;
        issue(8'd100, 8'd10);
        tick();
        tick();
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd3;
        tick();
        bus.start = 1'b0;
        cycles    = 3;
        unstable  = 0;
        while (bus.done !== 1'b1 && cycles < MAXWAIT) begin
            bus.dividend = 8'($urandom);
            bus.divisor  = 8'($urandom);
            if (bus.quotient !== lastQ || bus.remainder !== lastR) unstable++;
            tick();
            cycles++;
        end
        checks++; if (cycles != WIDTH) begin errors++; $display("[TB] FAIL ignore_latency got %0d want %0d", cycles, WIDTH); end
        checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL ignore_outputs_held got %0d changed cycles want 0", unstable); end
        checks++; if (bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin errors++; $display("[TB] FAIL ignore_result got q=%0d r=%0d want 10/0", bus.quotient, bus.remainder); end
        lastQ    = 8'd10;
        lastR    = 8'd0;
        unstable = 0;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.dividend = 8'($urandom);
            bus.divisor  = 8'($urandom);
            if (bus.quotient !== lastQ || bus.remainder !== lastR) unstable++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
        end
        checks++; if (unstable != 0 || spurious != 0) begin errors++; $display("[TB] FAIL ignore_hold got changed=%0d active=%0d want 0/0", unstable, spurious); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, q, r;
        logic             z;
        int               lat, cycles, busyCnt, gap;
        for (int n = 0; n < 40; n++) begin
            a   = 8'($urandom_range(0, 255));
            b   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            gap = $urandom_range(0, 2);
            refDiv(a, b, q, r, z, lat);
            for (int g = 0; g < gap; g++) tick();
            issue(a, b);
            bus.dividend = 8'($urandom);
            bus.divisor  = 8'($urandom);
            waitDone(cycles, busyCnt);
            checks++; if (cycles != lat) begin errors++; $display("[TB] FAIL rand_latency %0d/%0d got %0d want %0d", a, b, cycles, lat); end
            checks++; if (busyCnt != lat) begin errors++; $display("[TB] FAIL rand_busy %0d/%0d got %0d want %0d", a, b, busyCnt, lat); end
            checks++; if (bus.quotient !== q) begin errors++; $display("[TB] FAIL rand_quotient %0d/%0d got %0d want %0d", a, b, bus.quotient, q); end
            checks++; if (bus.remainder !== r) begin errors++; $display("[TB] FAIL rand_remainder %0d/%0d got %0d want %0d", a, b, bus.remainder, r); end
            checks++; if (bus.div_by_zero !== z) begin errors++; $display("[TB] FAIL rand_dbz %0d/%0d got %0b want %0b", a, b, bus.div_by_zero, z); end
            lastQ = q;
            lastR = r;
        end
        tick();
    endtask

    task automatic test_div_zero();
        logic [WIDTH-1:0] q, r;
        logic             z;
        int               lat, cycles, busyCnt;
        refDiv(8'd77, 8'd0, q, r, z, lat);
        issue(8'd77, 8'd0);
        bus.dividend = 8'd12;
        bus.divisor  = 8'd4;
        waitDone(cycles, busyCnt);
        checks++; if (cycles != lat) begin errors++; $display("[TB] FAIL dz_latency got %0d want %0d", cycles, lat); end
        checks++; if (busyCnt != lat) begin errors++; $display("[TB] FAIL dz_busy_cycles got %0d want %0d", busyCnt, lat); end
        checks++; if (bus.quotient !== 8'd255 || bus.remainder !== 8'd77) begin errors++; $display("[TB] FAIL dz_result got q=%0d r=%0d want 255/77", bus.quotient, bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL dz_flag got %0b want 1", bus.div_by_zero); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL dz_done_pulse got %0b want 0", bus.done); end
    endtask

    task automatic test_reset_abort();
        int cycles, busyCnt, seen;
        issue(8'd200, 8'd7);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_ctrl got busy=%0b done=%0b want 0/0", bus.busy, bus.done); end
        checks++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL abort_outputs got q=%0d r=%0d z=%0b want 0/0/0", bus.quotient, bus.remainder, bus.div_by_zero); end
        tick();
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d active cycles want 0", seen); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        issue(8'd9, 8'd2);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL first_edge_accept got busy=%0b want 1", bus.busy); end
        waitDone(cycles, busyCnt);
        checks++; if (cycles != WIDTH) begin errors++; $display("[TB] FAIL post_reset_latency got %0d want %0d", cycles, WIDTH); end
        checks++; if (bus.quotient !== 8'd4 || bus.remainder !== 8'd1) begin errors++; $display("[TB] FAIL post_reset_result got q=%0d r=%0d want 4/1", bus.quotient, bus.remainder); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_random();
        test_div_zero();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
